// File: rtl/syndrome_round_feeder_pkg.sv
// Shared constants, helpers and issue-FSM state type for the syndrome round feeder.
`ifndef SYNDROME_ROUND_FEEDER_MAX
`define SYNDROME_ROUND_FEEDER_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif

package syndrome_round_feeder_pkg;

    localparam int DEFAULT_DX         = 3;
    localparam int DEFAULT_DZ         = 2;
    localparam int MEASUREMENT_ROUNDS = `SYNDROME_ROUND_FEEDER_MAX(DEFAULT_DX, DEFAULT_DZ);
    localparam int PU_COUNT           = DEFAULT_DX * DEFAULT_DZ * MEASUREMENT_ROUNDS;

    typedef enum logic {
        FEED_FREE,
        FEED_DECODING
    } feed_state_t;

    function automatic int pu_count(input int dx, input int dz);
        return dx * dz * `SYNDROME_ROUND_FEEDER_MAX(dx, dz);
    endfunction

    function automatic int word_count(input int bits, input int width);
        return (bits + width - 1) / width;
    endfunction

endpackage

// File: rtl/syndrome_word_assembler.sv
// Collects one round of stream words into a flat measurement buffer and flags framing errors.
module syndrome_word_assembler
    import syndrome_round_feeder_pkg::*;
#(
    parameter int  PU_CNT      = PU_COUNT,
    parameter int  INPUT_WIDTH = 8,
    localparam int NUM_WORDS   = word_count(PU_CNT, INPUT_WIDTH),
    localparam int IDX_W       = `SYNDROME_ROUND_FEEDER_MAX(1, $clog2(NUM_WORDS))
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   consume,
    output logic                   full,
    output logic [PU_CNT-1:0]      buffer,
    output logic                   frame_error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             at_last;
    logic             good_mid;
    logic             good_end;
    logic             store;

    assign s_ready  = !full;
    assign accept   = s_valid && !full;
    assign at_last  = (idx == LAST_IDX);
    assign good_mid = accept && !at_last && !s_last;
    assign good_end = accept &&  at_last &&  s_last;
    assign store    = good_mid || good_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            full        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (good_mid)
                idx <= idx + IDX_W'(1);
            else if (accept)
                idx <= '0;

            if (good_end)
                full <= 1'b1;
            else if (consume)
                full <= 1'b0;

            // Any accepted word that is neither a clean mid-frame nor a clean end drops the frame.
            if (accept && !store)
                frame_error <= 1'b1;
        end
    end

    // Bits past PU_CNT in the final word have no home and are never stored.
    for (genvar b = 0; b < PU_CNT; b++) begin : g_bit
        localparam logic [IDX_W-1:0] WORD_OF_BIT = IDX_W'(b / INPUT_WIDTH);
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                buffer[b] <= 1'b0;
            else if (store && (idx == WORD_OF_BIT))
                buffer[b] <= s_data[b % INPUT_WIDTH];
        end
    end

endmodule

// File: rtl/syndrome_round_feeder.sv
// Issues assembled syndrome rounds to the decoder, one at a time, while the next round streams in.
//   state         | meaning
//   FEED_FREE     | decoder idle; issue as soon as the assembler holds a full round
//   FEED_DECODING | round issued; waiting for result_valid
module syndrome_round_feeder
    import syndrome_round_feeder_pkg::*;
#(
    parameter int  CODE_DISTANCE_X = 3,
    parameter int  CODE_DISTANCE_Z = 2,
    parameter int  INPUT_WIDTH     = 8,
    localparam int PU_CNT          = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INPUT_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [PU_CNT-1:0]      measurements,
    output logic                   new_round_start,
    input  logic                   result_valid,
    output logic                   decoder_busy,
    output logic                   frame_error,
    output logic [15:0]            rounds_issued
);

    feed_state_t       state_q;
    feed_state_t       state_d;
    logic              issue;
    logic              full;
    logic [PU_CNT-1:0] buffer;

    syndrome_word_assembler #(
        .PU_CNT      (PU_CNT),
        .INPUT_WIDTH (INPUT_WIDTH)
    ) u_assembler (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .consume     (issue),
        .full        (full),
        .buffer      (buffer),
        .frame_error (frame_error)
    );

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            FEED_FREE: begin
                if (full) begin
                    issue   = 1'b1;
                    state_d = FEED_DECODING;
                end
            end
            FEED_DECODING: begin
                if (result_valid)
                    state_d = FEED_FREE;
            end
            default: state_d = FEED_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= FEED_FREE;
            measurements    <= '0;
            new_round_start <= 1'b0;
            rounds_issued   <= 16'd0;
        end else begin
            state_q         <= state_d;
            new_round_start <= issue;
            if (issue) begin
                measurements  <= buffer;
                rounds_issued <= rounds_issued + 16'd1;
            end
        end
    end

    assign decoder_busy = (state_q == FEED_DECODING);

endmodule
